// File: rtl/pyramid_level_sequencer.sv
// Walks a 4/5-per-level image pyramid: emits level 0, then drives the external width/height
// calculators level by level until a dimension drops below MIN_DIM or MAX_LEVELS is reached.
// Optional PYRAMID_ERR_EN adds o_err and rejects undersized base images at start.
module pyramid_level_sequencer #(
  parameter int COORD_BITS = 16,
  parameter int LEVEL_BITS = 4,
  parameter int MAX_LEVELS = 8,
  parameter int MIN_DIM    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [COORD_BITS-1:0] i_base_width,
  input  logic [COORD_BITS-1:0] i_base_height,
  output logic                  o_calc_in_valid,
  output logic [COORD_BITS-1:0] o_calc_in_width,
  output logic [COORD_BITS-1:0] o_calc_in_height,
  input  logic                  i_calc_out_valid,
  input  logic [COORD_BITS-1:0] i_calc_out_width,
  input  logic [COORD_BITS-1:0] i_calc_out_height,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [LEVEL_BITS-1:0] o_out_level,
  output logic [COORD_BITS-1:0] o_out_width,
  output logic [COORD_BITS-1:0] o_out_height,
  output logic                  o_out_last,
  output logic                  o_busy,
  output logic                  o_done
`ifdef PYRAMID_ERR_EN
  ,
  output logic                  o_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_EMIT} state_t;

  localparam logic [COORD_BITS-1:0] LP_MIN      = COORD_BITS'(MIN_DIM);
  localparam logic [LEVEL_BITS:0]   LP_LAST_LVL = (LEVEL_BITS+1)'(MAX_LEVELS - 1);
  localparam bit                    LP_SINGLE   = (MAX_LEVELS == 1);

  state_t                r_state;
  logic [COORD_BITS-1:0] r_cur_w, r_cur_h, r_nxt_w, r_nxt_h, r_ci_w, r_ci_h;
  logic [LEVEL_BITS-1:0] r_level;
  logic                  r_last, r_ci_valid, r_out_valid, r_busy, r_done;

  logic                  w_base_small, w_res_small, w_reject, w_hs;
  logic [LEVEL_BITS:0]   w_level_inc;

  assign w_base_small = (i_base_width < LP_MIN) || (i_base_height < LP_MIN);
  assign w_res_small  = (i_calc_out_width < LP_MIN) || (i_calc_out_height < LP_MIN);
  assign w_hs         = r_out_valid && i_out_ready;
  assign w_level_inc  = {1'b0, r_level} + (LEVEL_BITS+1)'(1);

`ifdef PYRAMID_ERR_EN
  logic r_err;
  assign w_reject = w_base_small;
  assign o_err    = r_err;
`else
  assign w_reject = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cur_w     <= '0;
      r_cur_h     <= '0;
      r_nxt_w     <= '0;
      r_nxt_h     <= '0;
      r_ci_w      <= '0;
      r_ci_h      <= '0;
      r_level     <= '0;
      r_last      <= 1'b0;
      r_ci_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef PYRAMID_ERR_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_ci_valid <= 1'b0;
      r_done     <= 1'b0;
`ifdef PYRAMID_ERR_EN
      r_err      <= (r_state == S_IDLE) && i_start && w_base_small;
`endif
      case (r_state)
        S_IDLE: begin
          if (i_start && !w_reject) begin
            r_cur_w <= i_base_width;
            r_cur_h <= i_base_height;
            r_level <= '0;
            r_busy  <= 1'b1;
            // An undersized base can only get here with the error check disabled: emit it alone.
            if (LP_SINGLE || w_base_small) begin
              r_last      <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= S_EMIT;
            end else begin
              r_last     <= 1'b0;
              r_ci_valid <= 1'b1;
              r_ci_w     <= i_base_width;
              r_ci_h     <= i_base_height;
              r_state    <= S_CALC;
            end
          end
        end
        S_CALC: begin
          // A strobe coinciding with our own request pulse predates the restart, so it is stale.
          if (i_calc_out_valid && !r_ci_valid) begin
            r_nxt_w     <= i_calc_out_width;
            r_nxt_h     <= i_calc_out_height;
            r_last      <= w_res_small;
            r_out_valid <= 1'b1;
            r_state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (w_hs) begin
            if (r_last) begin
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_cur_w <= r_nxt_w;
              r_cur_h <= r_nxt_h;
              r_level <= w_level_inc[LEVEL_BITS-1:0];
              if (w_level_inc == LP_LAST_LVL) begin
                r_last <= 1'b1;
              end else begin
                r_out_valid <= 1'b0;
                r_ci_valid  <= 1'b1;
                r_ci_w      <= r_nxt_w;
                r_ci_h      <= r_nxt_h;
                r_state     <= S_CALC;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_calc_in_valid  = r_ci_valid;
  assign o_calc_in_width  = r_ci_w;
  assign o_calc_in_height = r_ci_h;
  assign o_out_valid      = r_out_valid;
  assign o_out_level      = r_level;
  assign o_out_width      = r_cur_w;
  assign o_out_height     = r_cur_h;
  assign o_out_last       = r_last;
  assign o_busy           = r_busy;
  assign o_done           = r_done;

endmodule
